bmp_upload: RTL



---
 rtl/bmp_pkg.sv | 22 ++
 rtl/bmp_hdr_rom.sv | 27 ++
 rtl/bmp_upload.sv | 97 +++++++++
 3 files changed

// File: rtl/bmp_pkg.sv
// bmp_pkg: BMP header layout, format constants and file-length helpers shared by upload and download sides
package bmp_pkg;
  localparam int BMP_BPP = 32;
  localparam int DIB_LEN = 40;
  localparam int OFS_SIG = 0;
  localparam int OFS_FSIZE = 2;
  localparam int OFS_RSVD = 6;
  localparam int OFS_DATA = 10;
  localparam int OFS_DIB = 14;
  localparam int OFS_W = 18;
  localparam int OFS_H = 22;
  localparam int OFS_PLANES = 26;
  localparam int OFS_BPP = 28;
  localparam int OFS_END = 30;
  typedef enum logic [2:0] {IDLE, HDR, FETCH, WAIT, READY, PAST} upl_state_t;
  function automatic logic [31:0] bmp_file_len(input logic [31:0] hdr_len, input logic [31:0] w, input logic [31:0] h);
    return hdr_len + w * h * 32'(BMP_BPP / 8);
  endfunction
  function automatic logic [7:0] le_byte(input logic [31:0] v, input logic [1:0] k);
    return 8'(v >> {k, 3'b000});
  endfunction
endpackage

// File: rtl/bmp_hdr_rom.sv
// bmp_hdr_rom: combinational BMP/DIB header byte generator for a 32-bpp bottom-up image
module bmp_hdr_rom
  import bmp_pkg::*;
#(
  parameter int HDR_LEN = 54
) (
  input  logic [31:0] index,
  input  logic [31:0] width,
  input  logic [31:0] height,
  output logic [7:0]  data
);
  logic [31:0] file_len;
  assign file_len = bmp_file_len(32'(HDR_LEN), width, height);
  // each field is a little-endian slice selected by the byte index
  always_comb
    data = index == 32'(OFS_SIG)     ? 8'h42 :
           index == 32'(OFS_SIG + 1) ? 8'h4D :
           index <  32'(OFS_RSVD)    ? le_byte(file_len, 2'(index - 32'(OFS_FSIZE))) :
           index <  32'(OFS_DATA)    ? 8'h00 :
           index <  32'(OFS_DIB)     ? le_byte(32'(HDR_LEN), 2'(index - 32'(OFS_DATA))) :
           index <  32'(OFS_W)       ? le_byte(32'(DIB_LEN), 2'(index - 32'(OFS_DIB))) :
           index <  32'(OFS_H)       ? le_byte(width, 2'(index - 32'(OFS_W))) :
           index <  32'(OFS_PLANES)  ? le_byte(height, 2'(index - 32'(OFS_H))) :
           index == 32'(OFS_PLANES)  ? 8'd1 :
           index == 32'(OFS_BPP)     ? 8'(BMP_BPP) :
           8'h00;
endmodule

// File: rtl/bmp_upload.sv
// bmp_upload: serves the SDRAM frame buffer as a 32-bpp BMP file to data_io, one byte at a time
module bmp_upload
  import bmp_pkg::*;
#(
  parameter int WIDTH   = 640,
  parameter int HEIGHT  = 312,
  parameter int HDR_LEN = 54,
  parameter int SD_BASE = 0
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_upload,
  input  logic [24:0] ioctl_addr,
  input  logic        ioctl_wr,
  output logic [7:0]  ioctl_din,
  output logic        port_req,
  input  logic        port_ack,
  output logic [22:0] port_a,
  output logic [1:0]  port_ds,
  output logic        port_we,
  input  logic [15:0] port_q,
  output logic        upl_busy
);
  localparam logic [31:0] FILE_LEN = bmp_file_len(32'(HDR_LEN), 32'(WIDTH), 32'(HEIGHT));
  upl_state_t state, nxt;
  logic        upl_q, in_hdr, past, hit, acked;
  logic [15:0] word;
  logic [7:0]  hdr_byte, hdr_din;
  logic [31:0] a;
  logic [23:0] p;
  assign a       = 32'(ioctl_addr);
  assign p       = 24'(32'(SD_BASE) + a - 32'(HDR_LEN));
  assign in_hdr  = a < 32'(HDR_LEN);
  assign past    = a >= FILE_LEN;
  assign nxt     = in_hdr ? HDR : past ? PAST : FETCH;
  assign hit     = nxt == FETCH && p[23:1] == port_a;
  assign acked   = port_ack == port_req;
  assign hdr_din = in_hdr ? hdr_byte : 8'h00;
  assign port_we = 1'b0;
  assign port_ds = 2'b11;
  bmp_hdr_rom #(.HDR_LEN(HDR_LEN)) u_hdr (
    .index (a),
    .width (32'(WIDTH)),
    .height(32'(HEIGHT)),
    .data  (hdr_byte)
  );
  // upload FSM: the current address is always the newest one, so re-evaluating it after an ack covers strobes seen mid-fetch
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= IDLE;
      ioctl_din <= 8'h00;
      port_req  <= port_ack;
      port_a    <= '0;
      upl_busy  <= 1'b0;
      word      <= '0;
      upl_q     <= 1'b0;
    end else begin
      upl_q <= ioctl_upload;
      if (!ioctl_upload) begin
        state     <= IDLE;
        upl_busy  <= 1'b0;
        ioctl_din <= hdr_din;
      end else begin
        case (state)
          IDLE: begin
            ioctl_din <= hdr_din;
            if (!upl_q) state <= nxt;
          end
          HDR: begin
            ioctl_din <= hdr_din;
            if (ioctl_wr && !in_hdr) state <= nxt;
          end
          FETCH:
            if (nxt != FETCH) state <= nxt;
            else if (acked) begin
              port_a   <= p[23:1];
              port_req <= ~port_req;
              upl_busy <= 1'b1;
              state    <= WAIT;
            end
          WAIT:
            if (acked) begin
              word      <= port_q;
              ioctl_din <= past ? 8'h00 : p[0] ? port_q[15:8] : port_q[7:0];
              upl_busy  <= 1'b0;
              state     <= hit ? READY : nxt;
            end
          READY: begin
            ioctl_din <= past ? 8'h00 : p[0] ? word[15:8] : word[7:0];
            if (ioctl_wr && !hit) state <= nxt;
          end
          default: ioctl_din <= hdr_din;
        endcase
      end
    end
  end
endmodule
